ecsu_multi_sector: RTL and testbench

//  Parametrised multi-sector Environmental Control & Safety Unit. Runs one weather-risk FSM per airspace sector,

---
 rtl/ecsu_pkg.sv | 40 ++++
 rtl/ecsu_sector_fsm.sv | 106 ++++++++++
 rtl/ecsu_multi_sector.sv | 96 +++++++++
 tb/tb_ecsu_multi_sector.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecsu_pkg.sv
// Shared state encodings, default thresholds and helpers for the multi-sector
// environmental control & safety unit.
package ecsu_pkg;

  localparam logic [1:0] ENC_ALL_CLEAR = 2'b00;
  localparam logic [1:0] ENC_CAUTION   = 2'b01;
  localparam logic [1:0] ENC_HIGH_RISK = 2'b10;
  localparam logic [1:0] ENC_EMERGENCY = 2'b11;

  typedef enum logic [1:0] {
    ST_ALL_CLEAR = ENC_ALL_CLEAR,
    ST_CAUTION   = ENC_CAUTION,
    ST_HIGH_RISK = ENC_HIGH_RISK,
    ST_EMERGENCY = ENC_EMERGENCY
  } ecsu_state_e;

  localparam int DEF_NUM_SECTORS  = 4;
  localparam int DEF_WIND_W       = 6;
  localparam int DEF_TEMP_W       = 8;
  localparam int DEF_DWELL_CYC    = 3;
  localparam int DEF_WIND_CAUTION = 10;
  localparam int DEF_WIND_SEVERE  = 15;
  localparam int DEF_WIND_EMERG   = 20;
  localparam int DEF_TEMP_SEVERE  = 35;
  localparam int DEF_TEMP_EMERG   = 40;

  localparam int EMERG_CNT_W = 16;
  localparam int POP_VEC_W   = 64;

  // Counts set bits of a vector of up to POP_VEC_W sectors.
  function automatic logic [EMERG_CNT_W-1:0] popcount(input logic [POP_VEC_W-1:0] vec);
    logic [EMERG_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_VEC_W; i++) begin
      cnt = cnt + EMERG_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ecsu_sector_fsm.sv
// One airspace sector: weather-risk FSM with immediate escalation, dwell-qualified
// downgrades and an acknowledged exit from EMERGENCY.
module ecsu_sector_fsm
  import ecsu_pkg::*;
#(
  parameter int WIND_W       = DEF_WIND_W,
  parameter int TEMP_W       = DEF_TEMP_W,
  parameter int DWELL_CYC    = DEF_DWELL_CYC,
  parameter int WIND_CAUTION = DEF_WIND_CAUTION,
  parameter int WIND_SEVERE  = DEF_WIND_SEVERE,
  parameter int WIND_EMERG   = DEF_WIND_EMERG,
  parameter int TEMP_SEVERE  = DEF_TEMP_SEVERE,
  parameter int TEMP_EMERG   = DEF_TEMP_EMERG
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_thunder,
  input  logic [WIND_W-1:0]        i_wind,
  input  logic [1:0]               i_vis,
  input  logic signed [TEMP_W-1:0] i_temp,
  input  logic                     i_ack,
  output logic [1:0]               o_state,
  output logic                     o_severe,
  output logic                     o_emerg,
  output logic                     o_enter
);

  localparam int DWELL_W = $clog2(DWELL_CYC + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL_CYC);

  ecsu_state_e        r_state;
  ecsu_state_e        w_nextState;
  logic [DWELL_W-1:0] r_dwell;

  logic [31:0]        w_wind;
  logic signed [31:0] w_temp;
  logic               w_sev;
  logic               w_emg;
  logic               w_cau;
  logic               w_calm;
  logic               w_clr;
  logic               w_dgCond;
  logic               w_dgDone;

  assign w_wind = 32'(i_wind);
  assign w_temp = 32'(i_temp);

  assign w_emg  = (w_wind > 32'(WIND_EMERG)) || (w_temp > TEMP_EMERG) || (w_temp < -TEMP_EMERG);
  assign w_sev  = i_thunder || (w_wind > 32'(WIND_SEVERE)) || (w_temp > TEMP_SEVERE) ||
                  (w_temp < -TEMP_SEVERE) || (i_vis == 2'b11);
  assign w_cau  = (w_wind > 32'(WIND_CAUTION)) || (i_vis == 2'b01) || (i_vis == 2'b10);
  assign w_calm = !w_sev && (w_wind <= 32'(WIND_CAUTION));
  assign w_clr  = w_calm && (i_vis == 2'b00);

  // A downgrade fires on the DWELL_CYC-th consecutive edge its condition holds.
  assign w_dgCond = ((r_state == ST_CAUTION) && w_clr) || ((r_state == ST_HIGH_RISK) && w_calm);
  assign w_dgDone = w_dgCond && (r_dwell == DWELL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ALL_CLEAR;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_ALL_CLEAR: begin
        if (w_sev)      w_nextState = ST_HIGH_RISK;
        else if (w_cau) w_nextState = ST_CAUTION;
      end
      ST_CAUTION: begin
        if (w_sev)         w_nextState = ST_HIGH_RISK;
        else if (w_dgDone) w_nextState = ST_ALL_CLEAR;
      end
      ST_HIGH_RISK: begin
        if (w_emg)         w_nextState = ST_EMERGENCY;
        else if (w_dgDone) w_nextState = ST_CAUTION;
      end
      ST_EMERGENCY: begin
        if (i_ack && !w_emg) w_nextState = ST_HIGH_RISK;
      end
      default: w_nextState = ST_ALL_CLEAR;
    endcase
  end

  // Any state change or a broken streak restarts the dwell count; it saturates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell <= '0;
    end else if ((w_nextState != r_state) || !w_dgCond) begin
      r_dwell <= '0;
    end else if (r_dwell != DWELL_MAX) begin
      r_dwell <= r_dwell + DWELL_W'(1);
    end
  end

  assign o_state  = r_state;
  assign o_severe = r_state[1];
  assign o_emerg  = (r_state == ST_EMERGENCY);
  assign o_enter  = (w_nextState == ST_EMERGENCY) && (r_state != ST_EMERGENCY);

endmodule

// File: rtl/ecsu_multi_sector.sv
// Multi-sector environmental control & safety unit: one FSM per sector plus a fleet
// summary and a saturating count of EMERGENCY entries.
module ecsu_multi_sector
  import ecsu_pkg::*;
#(
  parameter int NUM_SECTORS  = DEF_NUM_SECTORS,
  parameter int WIND_W       = DEF_WIND_W,
  parameter int TEMP_W       = DEF_TEMP_W,
  parameter int DWELL_CYC    = DEF_DWELL_CYC,
  parameter int WIND_CAUTION = DEF_WIND_CAUTION,
  parameter int WIND_SEVERE  = DEF_WIND_SEVERE,
  parameter int WIND_EMERG   = DEF_WIND_EMERG,
  parameter int TEMP_SEVERE  = DEF_TEMP_SEVERE,
  parameter int TEMP_EMERG   = DEF_TEMP_EMERG
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_SECTORS-1:0]        i_thunderstorm,
  input  logic [NUM_SECTORS*WIND_W-1:0] i_wind,
  input  logic [2*NUM_SECTORS-1:0]      i_visibility,
  input  logic [NUM_SECTORS*TEMP_W-1:0] i_temperature,
  input  logic [NUM_SECTORS-1:0]        i_emerg_ack,
  input  logic                          i_cnt_clr,
  output logic [2*NUM_SECTORS-1:0]      o_sector_state,
  output logic [NUM_SECTORS-1:0]        o_severe_weather,
  output logic [NUM_SECTORS-1:0]        o_emergency_landing_alert,
  output logic [1:0]                    o_worst_state,
  output logic                          o_any_emergency,
  output logic [EMERG_CNT_W-1:0]        o_emerg_count
);

  logic [2*NUM_SECTORS-1:0] w_stateVec;
  logic [NUM_SECTORS-1:0]   w_severeVec;
  logic [NUM_SECTORS-1:0]   w_alertVec;
  logic [NUM_SECTORS-1:0]   w_enterVec;
  logic [1:0]               w_worst;
  logic [EMERG_CNT_W-1:0]   w_newEntries;
  logic [EMERG_CNT_W:0]     w_sum;
  logic [EMERG_CNT_W-1:0]   r_emergCount;

  for (genvar g = 0; g < NUM_SECTORS; g++) begin : g_sector
    ecsu_sector_fsm #(
      .WIND_W      (WIND_W),
      .TEMP_W      (TEMP_W),
      .DWELL_CYC   (DWELL_CYC),
      .WIND_CAUTION(WIND_CAUTION),
      .WIND_SEVERE (WIND_SEVERE),
      .WIND_EMERG  (WIND_EMERG),
      .TEMP_SEVERE (TEMP_SEVERE),
      .TEMP_EMERG  (TEMP_EMERG)
    ) u_fsm (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_thunder(i_thunderstorm[g]),
      .i_wind   (i_wind[g*WIND_W +: WIND_W]),
      .i_vis    (i_visibility[2*g +: 2]),
      .i_temp   (i_temperature[g*TEMP_W +: TEMP_W]),
      .i_ack    (i_emerg_ack[g]),
      .o_state  (w_stateVec[2*g +: 2]),
      .o_severe (w_severeVec[g]),
      .o_emerg  (w_alertVec[g]),
      .o_enter  (w_enterVec[g])
    );
  end

  always_comb begin
    w_worst = ENC_ALL_CLEAR;
    for (int i = 0; i < NUM_SECTORS; i++) begin
      if (w_stateVec[2*i +: 2] > w_worst) w_worst = w_stateVec[2*i +: 2];
    end
  end

  // The popcount helper covers up to POP_VEC_W sectors.
  assign w_newEntries = popcount(POP_VEC_W'(w_enterVec));
  assign w_sum        = (EMERG_CNT_W+1)'(r_emergCount) + (EMERG_CNT_W+1)'(w_newEntries);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_emergCount <= '0;
    end else if (i_cnt_clr) begin
      r_emergCount <= '0;
    end else if (w_sum[EMERG_CNT_W]) begin
      r_emergCount <= '1;
    end else begin
      r_emergCount <= w_sum[EMERG_CNT_W-1:0];
    end
  end

  assign o_sector_state            = w_stateVec;
  assign o_severe_weather          = w_severeVec;
  assign o_emergency_landing_alert = w_alertVec;
  assign o_worst_state             = w_worst;
  assign o_any_emergency           = |w_alertVec;
  assign o_emerg_count             = r_emergCount;

endmodule

// File: tb/tb_ecsu_multi_sector.sv
// Self-checking bench for ecsu_multi_sector: a single-sector vector table plus
// hand-written dwell, acknowledge, saturation, async-reset and DWELL_CYC=1 sequences.
module tb_ecsu_multi_sector;

  logic        clk;
  logic        rstN;
  logic [3:0]  thunder;
  logic [23:0] wind;
  logic [7:0]  vis;
  logic [31:0] temp;
  logic [3:0]  ack;
  logic        cntClr;
  logic [7:0]  sectorState;
  logic [3:0]  severe;
  logic [3:0]  alert;
  logic [1:0]  worst;
  logic        anyEmerg;
  logic [15:0] emergCount;

  logic        thunder1;
  logic [5:0]  wind1;
  logic [1:0]  vis1;
  logic [7:0]  temp1;
  logic        ack1;
  logic [1:0]  state1;
  logic        severe1;
  logic        alert1;
  logic [1:0]  worst1;
  logic        anyEmerg1;
  logic [15:0] emergCount1;

  int tests = 0;
  int failures = 0;

  ecsu_multi_sector dut (
    .i_clk                    (clk),
    .i_rst_n                  (rstN),
    .i_thunderstorm           (thunder),
    .i_wind                   (wind),
    .i_visibility             (vis),
    .i_temperature            (temp),
    .i_emerg_ack              (ack),
    .i_cnt_clr                (cntClr),
    .o_sector_state           (sectorState),
    .o_severe_weather         (severe),
    .o_emergency_landing_alert(alert),
    .o_worst_state            (worst),
    .o_any_emergency          (anyEmerg),
    .o_emerg_count            (emergCount)
  );

  ecsu_multi_sector #(.NUM_SECTORS(1), .DWELL_CYC(1)) dutDwell1 (
    .i_clk                    (clk),
    .i_rst_n                  (rstN),
    .i_thunderstorm           (thunder1),
    .i_wind                   (wind1),
    .i_visibility             (vis1),
    .i_temperature            (temp1),
    .i_emerg_ack              (ack1),
    .i_cnt_clr                (1'b0),
    .o_sector_state           (state1),
    .o_severe_weather         (severe1),
    .o_emergency_landing_alert(alert1),
    .o_worst_state            (worst1),
    .o_any_emergency          (anyEmerg1),
    .o_emerg_count            (emergCount1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       th;
    logic [5:0] w;
    logic [1:0] v;
    logic [7:0] t;
    logic [1:0] exp1;
    logic [1:0] exp2;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected flags and summary derived from the expected per-sector states.
  task automatic checkFleet(input string tag, input logic [7:0] expVec, input logic [15:0] expCnt);
    logic [3:0] expSev;
    logic [3:0] expAlert;
    logic [1:0] expWorst;
    expSev   = '0;
    expAlert = '0;
    expWorst = 2'b00;
    for (int i = 0; i < 4; i++) begin
      expSev[i]   = expVec[2*i+1];
      expAlert[i] = expVec[2*i] & expVec[2*i+1];
      if (expVec[2*i +: 2] > expWorst) expWorst = expVec[2*i +: 2];
    end
    checkOutput({tag, ".state"},  32'(sectorState), 32'(expVec));
    checkOutput({tag, ".severe"}, 32'(severe),      32'(expSev));
    checkOutput({tag, ".alert"},  32'(alert),       32'(expAlert));
    checkOutput({tag, ".worst"},  32'(worst),       32'(expWorst));
    checkOutput({tag, ".any"},    32'(anyEmerg),    32'(|expAlert));
    checkOutput({tag, ".count"},  32'(emergCount),  32'(expCnt));
  endtask

  task automatic clearInputs();
    thunder = '0;
    wind    = '0;
    vis     = '0;
    temp    = '0;
    ack     = '0;
    cntClr  = 1'b0;
  endtask

  task automatic applyStimulus(input int s, input logic th, input logic [5:0] w,
                               input logic [1:0] v, input logic [7:0] t);
    thunder[s]      = th;
    wind[s*6 +: 6]  = w;
    vis[2*s +: 2]   = v;
    temp[s*8 +: 8]  = t;
  endtask

  task automatic setAllWind(input logic [5:0] w);
    for (int i = 0; i < 4; i++) wind[i*6 +: 6] = w;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
  endtask

  initial begin
    logic [7:0] expVec;

    vecs[0]  = '{1'b0, 6'd0,  2'd0, 8'd20,    2'b00, 2'b00};
    vecs[1]  = '{1'b0, 6'd10, 2'd0, 8'd0,     2'b00, 2'b00};
    vecs[2]  = '{1'b0, 6'd11, 2'd0, 8'd0,     2'b01, 2'b01};
    vecs[3]  = '{1'b0, 6'd0,  2'd1, 8'd0,     2'b01, 2'b01};
    vecs[4]  = '{1'b0, 6'd0,  2'd2, 8'd0,     2'b01, 2'b01};
    vecs[5]  = '{1'b0, 6'd0,  2'd3, 8'd0,     2'b10, 2'b10};
    vecs[6]  = '{1'b1, 6'd0,  2'd0, 8'd0,     2'b10, 2'b10};
    vecs[7]  = '{1'b0, 6'd15, 2'd0, 8'd0,     2'b01, 2'b01};
    vecs[8]  = '{1'b0, 6'd16, 2'd0, 8'd0,     2'b10, 2'b10};
    vecs[9]  = '{1'b0, 6'd20, 2'd0, 8'd0,     2'b10, 2'b10};
    vecs[10] = '{1'b0, 6'd21, 2'd0, 8'd0,     2'b10, 2'b11};
    vecs[11] = '{1'b0, 6'd0,  2'd0, 8'd35,    2'b00, 2'b00};
    vecs[12] = '{1'b0, 6'd0,  2'd0, 8'd36,    2'b10, 2'b10};
    vecs[13] = '{1'b0, 6'd0,  2'd0, 8'hDC,    2'b10, 2'b10};
    vecs[14] = '{1'b0, 6'd0,  2'd0, 8'hDD,    2'b00, 2'b00};
    vecs[15] = '{1'b0, 6'd0,  2'd0, 8'd40,    2'b10, 2'b10};
    vecs[16] = '{1'b0, 6'd0,  2'd0, 8'hD7,    2'b10, 2'b11};
    vecs[17] = '{1'b0, 6'd63, 2'd0, 8'd0,     2'b10, 2'b11};
    vecs[18] = '{1'b0, 6'd0,  2'd0, 8'h80,    2'b10, 2'b11};

    clearInputs();
    thunder1 = 1'b0;
    wind1    = '0;
    vis1     = '0;
    temp1    = '0;
    ack1     = 1'b0;
    rstN     = 1'b0;
    #2;
    checkFleet("reset", 8'h00, 16'h0000);
    #1;
    rstN = 1'b1;
    tick();

    // Single-sector vectors from ALL_CLEAR, rotated across sectors.
    for (int n = 0; n < 19; n++) begin
      int s;
      s = n % 4;
      clearInputs();
      doReset();
      applyStimulus(s, vecs[n].th, vecs[n].w, vecs[n].v, vecs[n].t);
      tick();
      expVec = 8'(vecs[n].exp1) << (2*s);
      checkFleet($sformatf("vec%0d.e1", n), expVec, 16'h0000);
      tick();
      expVec = 8'(vecs[n].exp2) << (2*s);
      checkFleet($sformatf("vec%0d.e2", n), expVec, (vecs[n].exp2 == 2'b11) ? 16'h0001 : 16'h0000);
    end

    // CAUTION -> ALL_CLEAR after three calm edges, then a glitch restarts the count.
    clearInputs();
    doReset();
    applyStimulus(0, 1'b0, 6'd12, 2'd0, 8'd0);
    tick(); checkFleet("dwell.enter", 8'h01, 16'h0);
    applyStimulus(0, 1'b0, 6'd5, 2'd0, 8'd0);
    tick(); checkFleet("dwell.c1", 8'h01, 16'h0);
    tick(); checkFleet("dwell.c2", 8'h01, 16'h0);
    tick(); checkFleet("dwell.c3", 8'h00, 16'h0);
    applyStimulus(0, 1'b0, 6'd12, 2'd0, 8'd0);
    tick(); checkFleet("glitch.enter", 8'h01, 16'h0);
    applyStimulus(0, 1'b0, 6'd5, 2'd0, 8'd0);
    tick(); checkFleet("glitch.c1", 8'h01, 16'h0);
    applyStimulus(0, 1'b0, 6'd12, 2'd0, 8'd0);
    tick(); checkFleet("glitch.spike", 8'h01, 16'h0);
    applyStimulus(0, 1'b0, 6'd5, 2'd0, 8'd0);
    tick(); checkFleet("glitch.r1", 8'h01, 16'h0);
    tick(); checkFleet("glitch.r2", 8'h01, 16'h0);
    tick(); checkFleet("glitch.r3", 8'h00, 16'h0);

    // HIGH_RISK -> CAUTION on sector 2 with calm wind but light visibility.
    applyStimulus(2, 1'b0, 6'd16, 2'd0, 8'd0);
    tick(); checkFleet("hr.enter", 8'h20, 16'h0);
    applyStimulus(2, 1'b0, 6'd5, 2'd1, 8'd0);
    tick(); checkFleet("hr.c1", 8'h20, 16'h0);
    tick(); checkFleet("hr.c2", 8'h20, 16'h0);
    tick(); checkFleet("hr.c3", 8'h10, 16'h0);
    tick(); checkFleet("hr.stay", 8'h10, 16'h0);

    // Sector 1 cold emergency and acknowledge handling.
    clearInputs();
    doReset();
    applyStimulus(1, 1'b0, 6'd0, 2'd0, 8'hD7);
    tick(); checkFleet("ack.hr", 8'h08, 16'h0);
    tick(); checkFleet("ack.em", 8'h0C, 16'h1);
    ack[1] = 1'b1;
    tick(); checkFleet("ack.ignored", 8'h0C, 16'h1);
    ack[1] = 1'b0;
    applyStimulus(1, 1'b0, 6'd0, 2'd0, 8'd0);
    tick(); checkFleet("ack.notRemembered", 8'h0C, 16'h1);
    ack[1] = 1'b1;
    tick(); checkFleet("ack.exit", 8'h08, 16'h1);
    ack[1] = 1'b0;

    // All four sectors escalate together.
    clearInputs();
    doReset();
    setAllWind(6'd25);
    tick(); checkFleet("all.hr", 8'hAA, 16'h0);
    tick(); checkFleet("all.em", 8'hFF, 16'h4);

    // Drive the counter to 16'hFFFE with repeated exit/re-entry of all sectors.
    cntClr = 1'b1;
    tick(); checkFleet("clr", 8'hFF, 16'h0);
    cntClr = 1'b0;
    for (int k = 0; k < 16383; k++) begin
      ack = 4'hF; setAllWind(6'd16); tick();
      ack = 4'h0; setAllWind(6'd25); tick();
    end
    checkFleet("loop", 8'hFF, 16'hFFFC);
    ack = 4'hF; setAllWind(6'd16); tick();
    ack = 4'h0; wind[0 +: 6] = 6'd25; wind[6 +: 6] = 6'd25;
    tick(); checkFleet("sat.fffe", 8'hAF, 16'hFFFE);
    ack = 4'hF; setAllWind(6'd16); tick();
    ack = 4'h0; wind[12 +: 6] = 6'd25; wind[18 +: 6] = 6'd25;
    tick(); checkFleet("sat.ffff", 8'hFA, 16'hFFFF);
    ack = 4'hF; setAllWind(6'd16); tick();
    ack = 4'h0; wind[0 +: 6] = 6'd25;
    tick(); checkFleet("sat.hold", 8'hAB, 16'hFFFF);
    ack = 4'hF; setAllWind(6'd16); tick();
    ack = 4'h0; setAllWind(6'd25); cntClr = 1'b1;
    tick(); checkFleet("clr.priority", 8'hFF, 16'h0);
    cntClr = 1'b0;

    // Asynchronous reset in the middle of a cycle while all sectors are in EMERGENCY.
    #2;
    rstN = 1'b0;
    #1;
    checkFleet("asyncReset", 8'h00, 16'h0);
    #1;
    rstN = 1'b1;
    clearInputs();
    tick();

    // DWELL_CYC=1 build downgrades on the first qualifying edge.
    wind1 = 6'd16;
    tick(); checkOutput("dwell1.hr", 32'(state1), 32'h2);
    wind1 = 6'd5;
    tick(); checkOutput("dwell1.caution", 32'(state1), 32'h1);
    tick(); checkOutput("dwell1.clear", 32'(state1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
